// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES S-box tables, widths and sequencer state encoding
package des_pkg;

  localparam int DES_SBOX_IN_W  = 6;
  localparam int DES_SBOX_OUT_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  // One 256-bit word per S-box: 64 nibbles, entry row*16+col, entry 0 in the MSBs
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [DES_SBOX_OUT_W-1:0] sbox_lookup(
    input logic [2:0]               sel,
    input logic [DES_SBOX_IN_W-1:0] din
  );
    logic [5:0]   idx;
    logic [255:0] word;
    int unsigned  sh;
    // row = outer bits {b5,b0}, column = inner bits b[4:1]
    idx  = {din[5], din[0], din[4:1]};
    sh   = 4 * (63 - int'(idx));
    word = SBOX[sel] >> sh;
    return word[DES_SBOX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// rtl/des_sbox_lane.sv - one combinational S-box lookup lane, box chosen by sel
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0]                sel,
  input  logic [DES_SBOX_IN_W-1:0]  din,
  output logic [DES_SBOX_OUT_W-1:0] dout
);

  assign dout = sbox_lookup(sel, din);

endmodule

// File: rtl/des_sbox_sequencer.sv
// rtl/des_sbox_sequencer.sv - time-multiplexes LANES S-box lanes over S1..S8
module des_sbox_sequencer
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int STEPS   = 8 / LANES;
  localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CHUNK_W = DES_SBOX_IN_W * LANES;
  localparam int NIB_W   = DES_SBOX_OUT_W * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_sequencer: LANES must be 1, 2, 4 or 8");
  end

  seq_state_t        state;
  logic [47:0]       sreg;
  logic [31:0]       acc;
  logic [CNT_W-1:0]  cnt;
  logic [NIB_W-1:0]  lane_bits;

  // Lane 0 takes the top chunk and lands in the most significant nibble
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [2:0] sel;
    logic [3:0] dout;
    assign sel = 3'(int'(cnt) * LANES + j);
    des_sbox_lane u_lane (
      .sel  (sel),
      .din  (sreg[47-6*j -: 6]),
      .dout (dout)
    );
    assign lane_bits[NIB_W-1-4*j -: 4] = dout;
  end

  assign out_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= RUN;
            sreg     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sreg <= sreg << CHUNK_W;
          acc  <= (acc << NIB_W) | 32'(lane_bits);
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// tb/tb_des_sbox_sequencer.sv - directed and random checks over LANES 1,2,4,8
module tb_des_sbox_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush     [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_data  [4];
  logic        busy      [4];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    des_sbox_sequencer #(.LANES(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .busy      (busy[k])
    );
  end

  // FIPS 46-3 S1..S8, each row written as 16 hex digits, rows 0..3 left to right
  logic [255:0] sb [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [31:0] ref_sbox(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      logic [5:0] c;
      int i;
      c = d[47-6*b -: 6];
      i = int'({c[5], c[0]}) * 16 + int'(c[4:1]);
      r = {r[27:0], sb[b][255-4*i -: 4]};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int k, input logic [47:0] d, input logic [31:0] exp,
                         input string tag);
    int lat;
    tick;
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    out_ready[k] = 1'b0;
    check({tag, "_in_ready"}, 64'(in_ready[k]), 64'd1);
    tick;
    in_valid[k] = 1'b0;
    in_data[k]  = 48'hDEAD_BEEF_CAFE;
    lat = 1;
    while (!out_valid[k] && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(8 / (1 << k) + 1));
    check({tag, "_data"}, 64'(out_data[k]), 64'(exp));
    out_ready[k] = 1'b1;
    tick;
    out_ready[k] = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid[k]), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready[k]), 64'd1);
  endtask

  task automatic rand_test(input int k, input int n);
    logic [31:0] q[$];
    int sent;
    int got;
    int cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < n * 40) begin
      @(posedge clk);
      #1;
      cyc++;
      in_valid[k]  = (($urandom % 3) != 0) && (sent < n);
      in_data[k]   = {16'($urandom()), 32'($urandom())};
      out_ready[k] = ($urandom % 4) != 0;
      @(negedge clk);
      if (in_valid[k] && in_ready[k]) begin
        q.push_back(ref_sbox(in_data[k]));
        sent++;
      end
      if (out_valid[k] && out_ready[k]) begin
        if (q.size() == 0) check("rand_unexpected_out", 64'd1, 64'd0);
        else check("rand_data", 64'(out_data[k]), 64'(q.pop_front()));
        got++;
      end
    end
    check("rand_completed", 64'(got), 64'(n));
    @(posedge clk);
    #1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
  endtask

  initial begin
    int bad;
    int seen;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      flush[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 4; k++) begin
      check("reset_in_ready",  64'(in_ready[k]),  64'd1);
      check("reset_out_valid", 64'(out_valid[k]), 64'd0);
      check("reset_busy",      64'(busy[k]),      64'd0);
      check("reset_out_data",  64'(out_data[k]),  64'd0);
    end
    #10 rst_n = 1'b1;

    run_one(0, 48'h0, 32'hEFA72C4D, "zero_l1");
    run_one(0, 48'h03F0_0000_0000, 32'hE9A72C4D, "s2_iso_l1");
    for (int k = 0; k < 4; k++) run_one(k, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, "ones");
    run_one(3, 48'h0, 32'hEFA72C4D, "zero_l8");

    // backpressure on LANES=2: DONE must hold and ignore new input
    tick;
    in_valid[1] = 1'b1;
    in_data[1]  = 48'hFFFF_FFFF_FFFF;
    tick;
    in_valid[1] = 1'b0;
    seen = 0;
    while (!out_valid[1] && seen < 40) begin
      tick;
      seen++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = {16'($urandom()), 32'($urandom())};
      tick;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 32'hD9CE3DCB ||
          in_ready[1] !== 1'b0 || busy[1] !== 1'b1) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    tick;
    out_ready[1] = 1'b0;
    check("bp_release_ready", 64'(in_ready[1]), 64'd1);
    check("bp_release_valid", 64'(out_valid[1]), 64'd0);

    // flush at RUN cnt==3 on LANES=1
    tick;
    in_valid[0] = 1'b1;
    in_data[0]  = 48'hFFFF_FFFF_FFFF;
    tick;
    in_valid[0] = 1'b0;
    tick;
    tick;
    tick;
    check("flush_pre_busy", 64'(busy[0]), 64'd1);
    flush[0] = 1'b1;
    tick;
    flush[0] = 1'b0;
    check("flush_out_valid", 64'(out_valid[0]), 64'd0);
    check("flush_in_ready",  64'(in_ready[0]),  64'd1);
    check("flush_busy",      64'(busy[0]),      64'd0);
    check("flush_acc",       64'(out_data[0]),  64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid[0]) seen++;
    end
    check("flush_no_output", 64'(seen), 64'd0);
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 48'h1234_5678_9ABC;
    tick;
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    check("flush_beats_accept", 64'(busy[0]), 64'd0);
    run_one(0, 48'h0, 32'hEFA72C4D, "post_flush");

    // asynchronous reset mid-RUN
    tick;
    in_valid[0] = 1'b1;
    in_data[0]  = 48'hFFFF_FFFF_FFFF;
    tick;
    in_valid[0] = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("areset_in_ready",  64'(in_ready[0]),  64'd1);
    check("areset_out_valid", 64'(out_valid[0]), 64'd0);
    check("areset_busy",      64'(busy[0]),      64'd0);
    check("areset_out_data",  64'(out_data[0]),  64'd0);
    #3 rst_n = 1'b1;
    run_one(0, 48'h0, 32'hEFA72C4D, "post_reset");

    rand_test(0, 1000);
    for (int k = 1; k < 4; k++) rand_test(k, 200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
